// File: rtl/pcie_tlp_req_splitter.sv
// Splits NoC memory read/write requests into PCIe TLP descriptors.
// Chunks are bounded by MPS/MRRS and never cross a 4 KB boundary.
module pcie_tlp_req_splitter #(
  parameter int unsigned AXI_ADDR_WIDTH    = 48,
  parameter int unsigned MAX_PAYLOAD_SIZE  = 256,
  parameter int unsigned MAX_READ_REQ_SIZE = 4096
) (
  input  logic                      clk_sys,
  input  logic                      rst_sys,
  input  logic [2:0]                cfg_mps,
  input  logic [2:0]                cfg_mrrs,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_write,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [12:0]               req_len,
  input  logic [7:0]                req_tag,
  output logic                      tlp_valid,
  input  logic                      tlp_ready,
  output logic                      tlp_is_write,
  output logic [AXI_ADDR_WIDTH-1:0] tlp_addr,
  output logic [12:0]               tlp_len_bytes,
  output logic [10:0]               tlp_len_dw,
  output logic [3:0]                tlp_first_be,
  output logic [3:0]                tlp_last_be,
  output logic [7:0]                tlp_tag,
  output logic [5:0]                tlp_seq,
  output logic                      tlp_last,
  output logic                      busy,
  output logic                      err_len
);

  localparam int unsigned AW        = AXI_ADDR_WIDTH;
  localparam logic [12:0] MPS_CEIL  = 13'(MAX_PAYLOAD_SIZE);
  localparam logic [12:0] MRRS_CEIL = 13'(MAX_READ_REQ_SIZE);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t      state;
  logic [12:0] rem_q;
  logic [12:0] lim_q;

  logic [AW-1:0] nxt_addr;
  logic [12:0]   nxt_rem;
  logic [12:0]   nxt_lim;
  logic [12:0]   nxt_bnd;
  logic [12:0]   nxt_chunk;
  logic [1:0]    nxt_off;
  logic [1:0]    nxt_end;
  logic [13:0]   dw_sum;
  logic [10:0]   nxt_dw;
  logic [3:0]    nxt_fbe;
  logic [3:0]    nxt_lbe;

  function automatic logic [12:0] size_limit(input logic [2:0] cfg, input logic [12:0] ceil_b);
    logic [2:0]  c;
    logic [12:0] lim;
    c   = (cfg > 3'd5) ? 3'd5 : cfg;
    lim = 13'd128 << c;
    return (lim < ceil_b) ? lim : ceil_b;
  endfunction

  // Next chunk: from the incoming request in IDLE, else from the one being accepted.
  always_comb begin
    nxt_addr = req_addr;
    nxt_rem  = req_len;
    nxt_lim  = req_is_write ? size_limit(cfg_mps, MPS_CEIL) : size_limit(cfg_mrrs, MRRS_CEIL);
    if (state == S_EMIT) begin
      nxt_addr = tlp_addr + AW'(tlp_len_bytes);
      nxt_rem  = rem_q - tlp_len_bytes;
      nxt_lim  = lim_q;
    end
    nxt_bnd   = 13'd4096 - {1'b0, nxt_addr[11:0]};
    nxt_chunk = nxt_rem;
    if (nxt_lim < nxt_chunk) nxt_chunk = nxt_lim;
    if (nxt_bnd < nxt_chunk) nxt_chunk = nxt_bnd;
    nxt_off = nxt_addr[1:0];
    dw_sum  = 14'(nxt_off) + {1'b0, nxt_chunk} + 14'd3;
    nxt_dw  = 11'(dw_sum >> 2);
    nxt_end = nxt_off + nxt_chunk[1:0] - 2'd1;
    nxt_fbe = 4'hF << nxt_off;
    nxt_lbe = 4'hF >> (2'd3 - nxt_end);
    // A single-DW chunk folds both masks into first_be.
    if (nxt_dw == 11'd1) begin
      nxt_fbe = nxt_fbe & nxt_lbe;
      nxt_lbe = 4'h0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state         <= S_IDLE;
      rem_q         <= '0;
      lim_q         <= '0;
      req_ready     <= 1'b1;
      tlp_valid     <= 1'b0;
      tlp_is_write  <= 1'b0;
      tlp_addr      <= '0;
      tlp_len_bytes <= '0;
      tlp_len_dw    <= '0;
      tlp_first_be  <= '0;
      tlp_last_be   <= '0;
      tlp_tag       <= '0;
      tlp_seq       <= '0;
      tlp_last      <= 1'b0;
      busy          <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            if (req_len == 13'd0 || req_len > 13'd4096) begin
              err_len <= 1'b1;
            end else begin
              state         <= S_EMIT;
              req_ready     <= 1'b0;
              busy          <= 1'b1;
              tlp_valid     <= 1'b1;
              tlp_is_write  <= req_is_write;
              tlp_tag       <= req_tag;
              tlp_seq       <= '0;
              lim_q         <= nxt_lim;
              rem_q         <= nxt_rem;
              tlp_addr      <= nxt_addr;
              tlp_len_bytes <= nxt_chunk;
              tlp_len_dw    <= nxt_dw;
              tlp_first_be  <= nxt_fbe;
              tlp_last_be   <= nxt_lbe;
              tlp_last      <= (nxt_chunk == nxt_rem);
            end
          end
        end
        S_EMIT: begin
          if (tlp_ready) begin
            if (tlp_last) begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
              tlp_valid <= 1'b0;
            end else begin
              tlp_seq       <= tlp_seq + 6'd1;
              rem_q         <= nxt_rem;
              tlp_addr      <= nxt_addr;
              tlp_len_bytes <= nxt_chunk;
              tlp_len_dw    <= nxt_dw;
              tlp_first_be  <= nxt_fbe;
              tlp_last_be   <= nxt_lbe;
              tlp_last      <= (nxt_chunk == nxt_rem);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tlp_req_splitter.sv
// Randomized self-checking bench for pcie_tlp_req_splitter against a byte-level chunking model.
module tb_pcie_tlp_req_splitter;

  logic        clk_sys, rst_sys;
  logic [2:0]  cfg_mps, cfg_mrrs;
  logic        req_valid, req_ready, req_is_write;
  logic [47:0] req_addr;
  logic [12:0] req_len;
  logic [7:0]  req_tag;
  logic        tlp_valid, tlp_ready, tlp_is_write;
  logic [47:0] tlp_addr;
  logic [12:0] tlp_len_bytes;
  logic [10:0] tlp_len_dw;
  logic [3:0]  tlp_first_be, tlp_last_be;
  logic [7:0]  tlp_tag;
  logic [5:0]  tlp_seq;
  logic        tlp_last, busy, err_len;

  int n_chk  = 0;
  int n_fail = 0;

  logic [47:0] e_addr [64];
  int          e_len  [64];
  int          e_dw   [64];
  logic [3:0]  e_fbe  [64];
  logic [3:0]  e_lbe  [64];
  bit          e_last [64];
  int          e_n;

  pcie_tlp_req_splitter dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .cfg_mps(cfg_mps), .cfg_mrrs(cfg_mrrs),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_len(req_len), .req_tag(req_tag),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_is_write(tlp_is_write),
    .tlp_addr(tlp_addr), .tlp_len_bytes(tlp_len_bytes), .tlp_len_dw(tlp_len_dw),
    .tlp_first_be(tlp_first_be), .tlp_last_be(tlp_last_be), .tlp_tag(tlp_tag),
    .tlp_seq(tlp_seq), .tlp_last(tlp_last), .busy(busy), .err_len(err_len)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: walk the request byte by byte and mark which DW lane each byte hits.
  function automatic void build_model(input bit w, input logic [47:0] a, input int len);
    int c, lim, ceil_b, rem, bnd, ch, off, dw, p;
    logic [47:0] ad;
    c = w ? int'(cfg_mps) : int'(cfg_mrrs);
    if (c > 5) c = 5;
    lim    = 128 << c;
    ceil_b = w ? 256 : 4096;
    if (ceil_b < lim) lim = ceil_b;
    rem = len;
    ad  = a;
    e_n = 0;
    while (rem > 0 && e_n < 64) begin
      bnd = 4096 - int'(ad[11:0]);
      ch  = rem;
      if (lim < ch) ch = lim;
      if (bnd < ch) ch = bnd;
      off = int'(ad[1:0]);
      dw  = (off + ch + 3) / 4;
      e_fbe[e_n] = 4'h0;
      e_lbe[e_n] = 4'h0;
      for (int b = 0; b < ch; b++) begin
        p = off + b;
        if (p / 4 == 0) e_fbe[e_n][p % 4] = 1'b1;
        else if (p / 4 == dw - 1) e_lbe[e_n][p % 4] = 1'b1;
      end
      e_addr[e_n] = ad;
      e_len[e_n]  = ch;
      e_dw[e_n]   = dw;
      e_last[e_n] = (ch == rem);
      ad  = ad + 48'(ch);
      rem = rem - ch;
      e_n++;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the last chunk is taken.
  task automatic run_req(input bit w, input logic [47:0] a, input int len, input logic [7:0] tag,
                         input int stall_pct, input int hold0);
    logic [2:0]  sv_mps, sv_mrrs;
    logic [97:0] got, exp;
    int idx, cyc;
    bit rdy;
    build_model(w, a, len);
    req_valid = 1'b1; req_is_write = w; req_addr = a; req_len = 13'(len); req_tag = tag;
    tlp_ready = 1'b0;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    @(negedge clk_sys);
    req_valid = 1'b0;
    sv_mps = cfg_mps; sv_mrrs = cfg_mrrs;
    cfg_mps = 3'($urandom); cfg_mrrs = 3'($urandom);
    idx = 0; cyc = 0;
    while (idx < e_n && cyc < 600) begin
      got = {tlp_valid, busy, tlp_is_write, tlp_addr, tlp_len_bytes, tlp_len_dw, tlp_first_be,
             tlp_last_be, tlp_tag, tlp_seq, tlp_last};
      exp = {2'b11, w, e_addr[idx], 13'(e_len[idx]), 11'(e_dw[idx]), e_fbe[idx], e_lbe[idx],
             tag, 6'(idx), e_last[idx]};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL chunk[%0d] req addr=%h len=%0d: got %h expected %h", idx, a, len, got, exp);
      end
      rdy = ($urandom_range(99) >= stall_pct) && !(idx == 0 && cyc < hold0);
      tlp_ready = rdy;
      @(negedge clk_sys);
      if (rdy) idx++;
      cyc++;
    end
    tlp_ready = 1'b0;
    cfg_mps = sv_mps; cfg_mrrs = sv_mrrs;
    if (idx < e_n) begin
      n_chk++; n_fail++;
      $display("FAIL chunk_timeout: got %0d chunks expected %0d", idx, e_n);
    end
    n_chk++;
    if ({tlp_valid, busy, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL done_state: got valid/busy/ready=%b expected 001", {tlp_valid, busy, req_ready});
    end
  endtask

  task automatic check_all_reset(input string name);
    logic [106:0] outs;
    outs = {tlp_valid, tlp_is_write, tlp_addr, tlp_len_bytes, tlp_len_dw, tlp_first_be,
            tlp_last_be, tlp_tag, tlp_seq, tlp_last, busy, err_len, ~req_ready};
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL %s: got outputs %h expected all zero with req_ready=1", name, outs);
    end
  endtask

  task automatic test_reset();
    rst_sys = 1'b1; req_valid = 1'b0; tlp_ready = 1'b0; req_is_write = 1'b0;
    req_addr = '0; req_len = '0; req_tag = '0; cfg_mps = 3'd1; cfg_mrrs = 3'd2;
    repeat (3) @(negedge clk_sys);
    check_all_reset("reset_values");
    rst_sys = 1'b0;
    @(negedge clk_sys);
    check_all_reset("idle_after_reset");
  endtask

  task automatic test_mps_split();
    cfg_mps = 3'd1;
    run_req(1'b1, 48'h1000, 512, 8'h11, 0, 0);
  endtask

  task automatic test_4k_cross();
    cfg_mrrs = 3'd2;
    run_req(1'b0, 48'h0FF0, 64, 8'h22, 0, 0);
  endtask

  task automatic test_byte_enables();
    cfg_mps = 3'd1;
    run_req(1'b1, 48'h2001, 2, 8'h33, 0, 0);
    run_req(1'b1, 48'h3002, 8, 8'h34, 0, 0);
    run_req(1'b0, 48'h4003, 1, 8'h35, 0, 0);
    run_req(1'b0, 48'h5FFD, 7, 8'h36, 0, 0);
  endtask

  task automatic test_ceiling_clamp();
    cfg_mps = 3'd7;
    run_req(1'b1, 48'h0, 4096, 8'h44, 0, 0);
    cfg_mps = 3'd0;
    run_req(1'b1, 48'h0ABC_0000_0081, 4096, 8'h45, 0, 0);
  endtask

  task automatic test_errors();
    int lens [2];
    lens[0] = 0;
    lens[1] = 4097;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_is_write = 1'b1; req_addr = 48'h100; req_len = 13'(lens[i]);
      @(negedge clk_sys);
      req_valid = 1'b0;
      n_chk++;
      if ({err_len, tlp_valid, busy, req_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL err_pulse len=%0d: got err/valid/busy/ready=%b expected 1001", lens[i],
                 {err_len, tlp_valid, busy, req_ready});
      end
      @(negedge clk_sys);
      n_chk++;
      if ({err_len, tlp_valid, busy, req_ready} !== 4'b0001) begin
        n_fail++;
        $display("FAIL err_clear len=%0d: got err/valid/busy/ready=%b expected 0001", lens[i],
                 {err_len, tlp_valid, busy, req_ready});
      end
    end
  endtask

  task automatic test_backpressure();
    cfg_mps = 3'd1;
    run_req(1'b1, 48'h7000, 512, 8'h55, 0, 5);
    cfg_mrrs = 3'd0;
    run_req(1'b0, 48'h7F42, 700, 8'h56, 50, 3);
  endtask

  task automatic test_reset_mid();
    cfg_mps = 3'd0;
    req_valid = 1'b1; req_is_write = 1'b1; req_addr = 48'h0; req_len = 13'd512; req_tag = 8'h5A;
    @(negedge clk_sys);
    req_valid = 1'b0; tlp_ready = 1'b1;
    @(negedge clk_sys);
    tlp_ready = 1'b0;
    n_chk++;
    if ({tlp_valid, tlp_seq} !== {1'b1, 6'd1}) begin
      n_fail++;
      $display("FAIL mid_chunk1: got valid=%b seq=%0d expected valid=1 seq=1", tlp_valid, tlp_seq);
    end
    rst_sys = 1'b1;
    @(negedge clk_sys);
    check_all_reset("reset_mid_request");
    rst_sys = 1'b0;
    @(negedge clk_sys);
    check_all_reset("idle_after_mid_reset");
    run_req(1'b1, 48'h8000, 300, 8'h5B, 0, 0);
  endtask

  task automatic test_back_to_back();
    cfg_mps = 3'd1; cfg_mrrs = 3'd0;
    run_req(1'b1, 48'h9000, 600, 8'h61, 0, 0);
    run_req(1'b0, 48'h9FFE, 260, 8'h62, 0, 0);
    run_req(1'b1, 48'hA003, 5, 8'h63, 0, 0);
  endtask

  task automatic test_random();
    logic [47:0] a;
    int len;
    for (int i = 0; i < 25; i++) begin
      cfg_mps  = 3'($urandom);
      cfg_mrrs = 3'($urandom);
      a = {16'($urandom), 32'($urandom)};
      if ($urandom_range(1) == 1) a[11:0] = 12'hFF0 + 12'($urandom_range(15));
      len = ($urandom_range(1) == 1) ? int'($urandom_range(300, 1)) : int'($urandom_range(4096, 1));
      run_req(1'($urandom), a, len, 8'($urandom), 30, 0);
    end
  endtask

  initial begin
    test_reset();
    test_mps_split();
    test_4k_cross();
    test_byte_enables();
    test_ceiling_clamp();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
